// File: rtl/regfile_pkg.sv
// Shared widths and dump-reader state encoding for the regfile debug path.
package regfile_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } dumpState_t;

endpackage

// File: rtl/out_skid_reg.sv
// One-entry valid/ready holding register for debug streamers.
module out_skid_reg #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              load,
    input  logic              clear,
    input  logic              ready,
    input  logic [DATA_W-1:0] loadData,
    input  logic [ADDR_W-1:0] loadIndex,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] index
);

    // clear beats load so a cancel never leaves a fresh word behind; data and
    // index only change on load, which keeps them frozen while stalled
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            valid <= 1'b0;
            data  <= '0;
            index <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= loadData;
            index <= loadIndex;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive regfile index range on a spare read port and streams
// each word out with valid/ready, tagged with its index.
module regfile_dump_reader #(
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] ctrl_readReg,
    input  logic [DATA_W-1:0] data_readReg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              busy,
    output logic              done,
    output logic              range_err
);

    import regfile_pkg::*;

    dumpState_t        state;
    dumpState_t        stateNext;
    logic [ADDR_W-1:0] counter;
    logic [ADDR_W-1:0] counterNext;
    logic [ADDR_W-1:0] lastReg;
    logic [ADDR_W-1:0] lastRegNext;
    logic              doneNext;
    logic              rangeErrNext;
    logic              load;
    logic              clear;

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state     <= IDLE;
            counter   <= '0;
            lastReg   <= '0;
            done      <= 1'b0;
            range_err <= 1'b0;
        end else begin
            state     <= stateNext;
            counter   <= counterNext;
            lastReg   <= lastRegNext;
            done      <= doneNext;
            range_err <= rangeErrNext;
        end
    end

    // A rejected start right after a done pulse is dropped so done can never
    // stay high for two cycles. The counter stops on last, so 31 never wraps.
    always_comb begin
        stateNext    = state;
        counterNext  = counter;
        lastRegNext  = lastReg;
        doneNext     = 1'b0;
        rangeErrNext = 1'b0;
        load         = 1'b0;
        clear        = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (first_reg <= last_reg) begin
                        counterNext = first_reg;
                        lastRegNext = last_reg;
                        stateNext   = READ;
                    end else if (!done) begin
                        doneNext     = 1'b1;
                        rangeErrNext = 1'b1;
                    end
                end
            end
            READ: begin
                if (abort) begin
                    clear     = 1'b1;
                    stateNext = IDLE;
                end else if (!out_valid || out_ready) begin
                    load = 1'b1;
                    if (counter == lastReg) begin
                        stateNext = DRAIN;
                    end else begin
                        counterNext = counter + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    clear     = 1'b1;
                    stateNext = IDLE;
                end else if (out_valid && out_ready) begin
                    doneNext  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign ctrl_readReg = counter;
    assign busy         = (state != IDLE);

    out_skid_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) outReg (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .load       (load),
        .clear      (clear),
        .ready      (out_ready),
        .loadData   (data_readReg),
        .loadIndex  (counter),
        .valid      (out_valid),
        .data       (out_data),
        .index      (out_index)
    );

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader against a range/queue model of a dump.
module tb_regfile_dump_reader;

    localparam int AW = regfile_pkg::ADDR_W;
    localparam int DW = regfile_pkg::DATA_W;

    typedef struct {
        int first;
        int last;
        int readyMode;
        int expWords;
        int expBusy;
    } vector_t;

    logic          clock = 1'b0;
    logic          ctrl_reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] first_reg = '0;
    logic [AW-1:0] last_reg = '0;
    logic [AW-1:0] ctrl_readReg;
    logic [AW-1:0] out_index;
    logic [DW-1:0] data_readReg;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          busy;
    logic          done;
    logic          range_err;

    logic [DW-1:0] regFile [32];
    vector_t       vectors [6];
    int            errors = 0;
    int            checks = 0;

    always #5 clock = ~clock;

    assign data_readReg = regFile[ctrl_readReg];

    regfile_dump_reader dut (
        .clock        (clock),
        .ctrl_reset   (ctrl_reset),
        .start        (start),
        .abort        (abort),
        .first_reg    (first_reg),
        .last_reg     (last_reg),
        .ctrl_readReg (ctrl_readReg),
        .data_readReg (data_readReg),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_index    (out_index),
        .busy         (busy),
        .done         (done),
        .range_err    (range_err)
    );

    function automatic logic [31:0] refData(input int k);
        if (k == 0) return 32'h0;
        return 32'h1000_0000 + 32'(k);
    endfunction

    // mode 0: always ready, 1: fixed 1,0,0,1,0,1 pattern, 2: random
    function automatic logic readyFor(input int mode, input int cyc);
        logic [5:0] pat;
        pat = 6'b101001;
        if (mode == 0) return 1'b1;
        if (mode == 1) return pat[cyc % 6];
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int first, input int last, input int mode,
                                 input int expWords, input int expBusy);
        int            expIdx;
        int            nXfer;
        int            cyc;
        int            busyCycles;
        int            firstValidCyc;
        bit            doneSeen;
        bit            holdPending;
        logic [DW-1:0] holdData;
        logic [AW-1:0] holdIdx;
        expIdx = first;
        nXfer = 0;
        cyc = 0;
        busyCycles = 0;
        firstValidCyc = -1;
        doneSeen = 1'b0;
        holdPending = 1'b0;
        holdData = '0;
        holdIdx = '0;
        first_reg = AW'(first);
        last_reg = AW'(last);
        start = 1'b1;
        out_ready = readyFor(mode, 0);
        while (!doneSeen && cyc < 200) begin
            bit xfer;
            bit finalXfer;
            if (holdPending) begin
                checkOutput("holdValid", 32'(out_valid), 32'd1);
                checkOutput("holdData", out_data, holdData);
                checkOutput("holdIndex", 32'(out_index), 32'(holdIdx));
            end
            xfer = out_valid && out_ready;
            finalXfer = 1'b0;
            if (out_valid && firstValidCyc < 0) firstValidCyc = cyc;
            if (xfer) begin
                checkOutput("index", 32'(out_index), 32'(expIdx));
                checkOutput("data", out_data, refData(expIdx));
                finalXfer = (expIdx == last);
                expIdx++;
                nXfer++;
            end
            holdPending = out_valid && !out_ready;
            holdData = out_data;
            holdIdx = out_index;
            if (busy) busyCycles++;
            tick();
            start = 1'b0;
            cyc++;
            checkOutput("done", 32'(done), 32'(finalXfer));
            checkOutput("rangeErr", 32'(range_err), 32'd0);
            if (finalXfer) doneSeen = 1'b1;
            out_ready = readyFor(mode, cyc);
        end
        checkOutput("doneReached", 32'(doneSeen), 32'd1);
        checkOutput("wordCount", 32'(nXfer), 32'(expWords));
        if (expBusy >= 0) checkOutput("busyCycles", 32'(busyCycles), 32'(expBusy));
        if (mode == 0) begin
            checkOutput("firstValidLatency", 32'(firstValidCyc), 32'd2);
            checkOutput("dumpCycles", 32'(cyc), 32'(expWords + 2));
        end
        tick();
        checkOutput("donePulseOnly", 32'(done), 32'd0);
        checkOutput("idleBusy", 32'(busy), 32'd0);
        checkOutput("idleValid", 32'(out_valid), 32'd0);
    endtask

    task automatic applyRangeError();
        first_reg = AW'(9);
        last_reg = AW'(2);
        start = 1'b1;
        out_ready = 1'b1;
        checkOutput("rangeBusyBefore", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        checkOutput("rangeDone", 32'(done), 32'd1);
        checkOutput("rangeErrPulse", 32'(range_err), 32'd1);
        checkOutput("rangeBusy", 32'(busy), 32'd0);
        checkOutput("rangeValid", 32'(out_valid), 32'd0);
        tick();
        checkOutput("rangeDoneDrop", 32'(done), 32'd0);
        checkOutput("rangeErrDrop", 32'(range_err), 32'd0);
        checkOutput("rangeValidAfter", 32'(out_valid), 32'd0);
    endtask

    task automatic applyAbort();
        int nX;
        int cyc;
        nX = 0;
        cyc = 0;
        first_reg = AW'(0);
        last_reg = AW'(31);
        start = 1'b1;
        out_ready = 1'b1;
        while (nX < 4 && cyc < 50) begin
            if (out_valid && out_ready) begin
                checkOutput("abortIndex", 32'(out_index), 32'(nX));
                nX++;
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        checkOutput("abortXfers", 32'(nX), 32'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abortValid", 32'(out_valid), 32'd0);
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortDone", 32'(done), 32'd0);
        repeat (3) begin
            tick();
            checkOutput("abortNoDone", 32'(done), 32'd0);
            checkOutput("abortStaysIdle", 32'(out_valid), 32'd0);
        end
        applyStimulus(10, 11, 0, 2, 3);
    endtask

    task automatic applyMidReset();
        first_reg = AW'(0);
        last_reg = AW'(31);
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        checkOutput("preResetValid", 32'(out_valid), 32'd1);
        #1;
        ctrl_reset = 1'b0;
        #1;
        checkOutput("rstValid", 32'(out_valid), 32'd0);
        checkOutput("rstData", out_data, 32'd0);
        checkOutput("rstIndex", 32'(out_index), 32'd0);
        checkOutput("rstReadReg", 32'(ctrl_readReg), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstRangeErr", 32'(range_err), 32'd0);
        tick();
        ctrl_reset = 1'b1;
        repeat (4) begin
            tick();
            checkOutput("postRstDone", 32'(done), 32'd0);
            checkOutput("postRstValid", 32'(out_valid), 32'd0);
            checkOutput("postRstBusy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin
            regFile[k] = (k == 0) ? 32'h0 : (32'h1000_0000 | 32'(k));
        end
        vectors[0] = '{first: 0,  last: 31, readyMode: 0, expWords: 32, expBusy: -1};
        vectors[1] = '{first: 5,  last: 5,  readyMode: 0, expWords: 1,  expBusy: 2};
        vectors[2] = '{first: 3,  last: 7,  readyMode: 1, expWords: 5,  expBusy: -1};
        vectors[3] = '{first: 31, last: 31, readyMode: 0, expWords: 1,  expBusy: 2};
        vectors[4] = '{first: 28, last: 31, readyMode: 2, expWords: 4,  expBusy: -1};
        vectors[5] = '{first: 0,  last: 0,  readyMode: 0, expWords: 1,  expBusy: 2};

        #1;
        checkOutput("resetValid", 32'(out_valid), 32'd0);
        checkOutput("resetData", out_data, 32'd0);
        checkOutput("resetIndex", 32'(out_index), 32'd0);
        checkOutput("resetReadReg", 32'(ctrl_readReg), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetRangeErr", 32'(range_err), 32'd0);
        tick();
        tick();
        ctrl_reset = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vectors[v].first, vectors[v].last, vectors[v].readyMode,
                          vectors[v].expWords, vectors[v].expBusy);
        end

        applyRangeError();
        applyAbort();
        applyMidReset();

        for (int r = 0; r < 6; r++) begin
            int a;
            int b;
            int t;
            a = int'($urandom_range(0, 31));
            b = int'($urandom_range(0, 31));
            if (a > b) begin
                t = a;
                a = b;
                b = t;
            end
            applyStimulus(a, b, 2, b - a + 1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
